// File: rtl/rv32v_ex_mem_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rv32v_ex_mem_skid_buffer
// Description : Elastic execute->memory pipeline stage for NUM_LANES vector
//               lanes. A 2-entry skid buffer (MAIN drives mem_*, SKID catches
//               one beat while MAIN is stalled) decouples ex_ready from
//               mem_ready, so execute never sees a combinational ready path.
//               Lanes with wen=0 are zeroed on capture. A saturating counter
//               records cycles where memory back-pressures a valid head beat.
// Ports       : CLK, nRST (async, active low), flush
//               ex_valid/ex_ready + ex_* payload        (execute side)
//               mem_valid/mem_ready + mem_* payload     (memory side)
//               occupancy (0..2 beats held), stall_cnt (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module rv32v_ex_mem_skid_buffer #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 32,
    parameter int OFFSET_W  = 4,
    parameter int IDX_W     = 3,
    parameter int CTRL_W    = 64,
    parameter int CNT_W     = 16
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          flush,
    // execute side
    input  logic                          ex_valid,
    output logic                          ex_ready,
    input  logic [NUM_LANES-1:0]          ex_wen,
    input  logic [NUM_LANES*DATA_W-1:0]   ex_aluresult,
    input  logic [NUM_LANES*DATA_W-1:0]   ex_storedata,
    input  logic [NUM_LANES*OFFSET_W-1:0] ex_woffset,
    input  logic [CTRL_W-1:0]             ex_ctrl,
    input  logic [IDX_W-1:0]              ex_index,
    input  logic                          ex_done,
    // memory side
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic [NUM_LANES-1:0]          mem_wen,
    output logic [NUM_LANES*DATA_W-1:0]   mem_aluresult,
    output logic [NUM_LANES*DATA_W-1:0]   mem_storedata,
    output logic [NUM_LANES*OFFSET_W-1:0] mem_woffset,
    output logic [CTRL_W-1:0]             mem_ctrl,
    output logic [IDX_W-1:0]              mem_index,
    output logic                          mem_done,
    // status
    output logic [1:0]                    occupancy,
    output logic [CNT_W-1:0]              stall_cnt
);

    // Packed payload layout: {done, index, ctrl, woffset, storedata, aluresult, wen}
    localparam int c_WEN_LSB  = 0;
    localparam int c_ALU_LSB  = c_WEN_LSB + NUM_LANES;
    localparam int c_SD_LSB   = c_ALU_LSB + NUM_LANES * DATA_W;
    localparam int c_WO_LSB   = c_SD_LSB + NUM_LANES * DATA_W;
    localparam int c_CTRL_LSB = c_WO_LSB + NUM_LANES * OFFSET_W;
    localparam int c_IDX_LSB  = c_CTRL_LSB + CTRL_W;
    localparam int c_DONE_BIT = c_IDX_LSB + IDX_W;
    localparam int c_PAY_W    = c_DONE_BIT + 1;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                          r_state;
    logic                            r_ex_ready;
    logic [c_PAY_W-1:0]              r_main;
    logic [c_PAY_W-1:0]              r_skid;
    logic [CNT_W-1:0]                r_stall_cnt;

    logic [NUM_LANES*DATA_W-1:0]     w_alu_m;
    logic [NUM_LANES*DATA_W-1:0]     w_sd_m;
    logic [NUM_LANES*OFFSET_W-1:0]   w_wo_m;
    logic [c_PAY_W-1:0]              w_in_pay;
    logic                            w_mem_valid;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_stall;

    // Disabled lanes are zeroed at capture so stale data never reaches memory.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_alu_m[g*DATA_W +: DATA_W]     = ex_wen[g] ? ex_aluresult[g*DATA_W +: DATA_W] : '0;
        assign w_sd_m[g*DATA_W +: DATA_W]      = ex_wen[g] ? ex_storedata[g*DATA_W +: DATA_W] : '0;
        assign w_wo_m[g*OFFSET_W +: OFFSET_W]  = ex_wen[g] ? ex_woffset[g*OFFSET_W +: OFFSET_W] : '0;
    end

    assign w_in_pay    = {ex_done, ex_index, ex_ctrl, w_wo_m, w_sd_m, w_alu_m, ex_wen};
    assign w_mem_valid = (r_state != S_EMPTY);
    // ex_ready is a register, so push never depends on mem_ready combinationally.
    assign w_push      = ex_valid && r_ex_ready;
    assign w_pop       = w_mem_valid && mem_ready;
    assign w_stall     = w_mem_valid && !mem_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_EMPTY;
            r_ex_ready  <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Debug counter survives flush; only reset clears it.
            if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end

            if (flush) begin
                // Any same-cycle push is dropped; a same-cycle pop was already
                // seen by memory and needs no action here.
                r_state    <= S_EMPTY;
                r_ex_ready <= 1'b1;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_push) begin
                            r_main  <= w_in_pay;
                            r_state <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_push && !w_pop) begin
                            r_skid     <= w_in_pay;
                            r_state    <= S_TWO;
                            r_ex_ready <= 1'b0;
                        end else if (!w_push && w_pop) begin
                            r_state <= S_EMPTY;
                        end else if (w_push && w_pop) begin
                            r_main <= w_in_pay;
                        end
                    end
                    S_TWO: begin
                        // ex_ready is low here, so the only event is a pop.
                        if (w_pop) begin
                            r_main     <= r_skid;
                            r_state    <= S_ONE;
                            r_ex_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_EMPTY;
                        r_ex_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ex_ready      = r_ex_ready;
    assign mem_valid     = w_mem_valid;
    assign mem_wen       = r_main[c_WEN_LSB +: NUM_LANES] & {NUM_LANES{w_mem_valid}};
    assign mem_aluresult = r_main[c_ALU_LSB +: NUM_LANES*DATA_W];
    assign mem_storedata = r_main[c_SD_LSB +: NUM_LANES*DATA_W];
    assign mem_woffset   = r_main[c_WO_LSB +: NUM_LANES*OFFSET_W];
    assign mem_ctrl      = r_main[c_CTRL_LSB +: CTRL_W];
    assign mem_index     = r_main[c_IDX_LSB +: IDX_W];
    assign mem_done      = r_main[c_DONE_BIT] & w_mem_valid;
    assign occupancy     = r_state;
    assign stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv32v_ex_mem_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32v_ex_mem_skid_buffer
// Description : Self-checking bench for rv32v_ex_mem_skid_buffer (4 lanes,
//               4-bit stall counter). A capacity-2 queue models the buffer;
//               each scenario task compares DUT outputs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32v_ex_mem_skid_buffer;

    localparam int L    = 4;
    localparam int DW   = 32;
    localparam int OW   = 4;
    localparam int IW   = 3;
    localparam int CW   = 64;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    typedef struct packed {
        logic          done;
        logic [IW-1:0] idx;
        logic [CW-1:0] ctrl;
        logic [L*OW-1:0] wo;
        logic [L*DW-1:0] sd;
        logic [L*DW-1:0] alu;
        logic [L-1:0]  wen;
    } beat_t;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [L-1:0]    ex_wen;
    logic [L*DW-1:0] ex_aluresult;
    logic [L*DW-1:0] ex_storedata;
    logic [L*OW-1:0] ex_woffset;
    logic [CW-1:0]   ex_ctrl;
    logic [IW-1:0]   ex_index;
    logic            ex_done;
    logic            mem_valid;
    logic            mem_ready;
    logic [L-1:0]    mem_wen;
    logic [L*DW-1:0] mem_aluresult;
    logic [L*DW-1:0] mem_storedata;
    logic [L*OW-1:0] mem_woffset;
    logic [CW-1:0]   mem_ctrl;
    logic [IW-1:0]   mem_index;
    logic            mem_done;
    logic [1:0]      occupancy;
    logic [CNTW-1:0] stall_cnt;

    rv32v_ex_mem_skid_buffer #(
        .NUM_LANES (L),
        .DATA_W    (DW),
        .OFFSET_W  (OW),
        .IDX_W     (IW),
        .CTRL_W    (CW),
        .CNT_W     (CNTW)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_wen        (ex_wen),
        .ex_aluresult  (ex_aluresult),
        .ex_storedata  (ex_storedata),
        .ex_woffset    (ex_woffset),
        .ex_ctrl       (ex_ctrl),
        .ex_index      (ex_index),
        .ex_done       (ex_done),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_wen       (mem_wen),
        .mem_aluresult (mem_aluresult),
        .mem_storedata (mem_storedata),
        .mem_woffset   (mem_woffset),
        .mem_ctrl      (mem_ctrl),
        .mem_index     (mem_index),
        .mem_done      (mem_done),
        .occupancy     (occupancy),
        .stall_cnt     (stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: FIFO of at most two beats plus a saturating stall count.
    beat_t q[$];
    int    mcnt;
    int    n_checks = 0;
    int    n_pass   = 0;

    // What the stage should store for the beat currently on ex_*.
    function automatic beat_t in_beat();
        beat_t b;
        b.wen  = ex_wen;
        b.alu  = ex_aluresult;
        b.sd   = ex_storedata;
        b.wo   = ex_woffset;
        b.ctrl = ex_ctrl;
        b.idx  = ex_index;
        b.done = ex_done;
        for (int i = 0; i < L; i++) begin
            if (!ex_wen[i]) begin
                b.alu[i*DW +: DW] = '0;
                b.sd[i*DW +: DW]  = '0;
                b.wo[i*OW +: OW]  = '0;
            end
        end
        return b;
    endfunction

    function automatic beat_t dut_head();
        beat_t b;
        b.wen  = mem_wen;
        b.alu  = mem_aluresult;
        b.sd   = mem_storedata;
        b.wo   = mem_woffset;
        b.ctrl = mem_ctrl;
        b.idx  = mem_index;
        b.done = mem_done;
        return b;
    endfunction

    task automatic rand_beat();
        logic [31:0] r;
        r            = $urandom;
        ex_wen       = r[3:0];
        ex_index     = r[6:4];
        ex_done      = r[7];
        ex_woffset   = r[31:16];
        ex_aluresult = {$urandom, $urandom, $urandom, $urandom};
        ex_storedata = {$urandom, $urandom, $urandom, $urandom};
        ex_ctrl      = {$urandom, $urandom};
    endtask

    // One clock: advance the model on the edge using the pre-edge inputs.
    task automatic tick();
        int sz;
        @(posedge CLK);
        if (nRST) begin
            sz = q.size();
            if (sz != 0 && !mem_ready && mcnt < CMAX) mcnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (sz != 0 && mem_ready) void'(q.pop_front());
                if (ex_valid && sz < 2) q.push_back(in_beat());
            end
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_valid); else n_pass++;
        n_checks++; if (ex_ready !== 1'b1) $display("FAIL reset_ex_ready: got %b want 1", ex_ready); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
        n_checks++; if (dut_head() !== '0) $display("FAIL reset_payload: got %h want 0", dut_head()); else n_pass++;
        nRST = 1'b1;
        q.delete();
        mcnt = 0;
        tick();
    endtask

    task automatic test_stream();
        beat_t exp;
        mem_ready = 1'b1;
        ex_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_beat();
            exp = in_beat();
            tick();
            n_checks++; if (mem_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, mem_valid); else n_pass++;
            n_checks++; if (dut_head() !== exp) $display("FAIL stream_payload[%0d]: got %h want %h", i, dut_head(), exp); else n_pass++;
            n_checks++; if (occupancy !== 2'd1) $display("FAIL stream_occupancy[%0d]: got %0d want 1", i, occupancy); else n_pass++;
        end
        ex_valid = 1'b0;
        tick();
        n_checks++; if (mem_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", mem_valid); else n_pass++;
        n_checks++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        beat_t a, b;
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        rand_beat(); a = in_beat(); tick();
        rand_beat(); b = in_beat(); tick();
        n_checks++; if (occupancy !== 2'd2) $display("FAIL bp_occupancy: got %0d want 2", occupancy); else n_pass++;
        n_checks++; if (ex_ready !== 1'b0) $display("FAIL bp_ex_ready: got %b want 0", ex_ready); else n_pass++;
        n_checks++; if (dut_head() !== a) $display("FAIL bp_head_a: got %h want %h", dut_head(), a); else n_pass++;
        // Offered beat while full must be ignored.
        rand_beat(); tick();
        n_checks++; if (occupancy !== 2'(q.size())) $display("FAIL bp_ignore: got %0d want %0d", occupancy, q.size()); else n_pass++;
        n_checks++; if (dut_head() !== a) $display("FAIL bp_stable: got %h want %h", dut_head(), a); else n_pass++;
        n_checks++; if (stall_cnt !== 4'(mcnt)) $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt, mcnt); else n_pass++;
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        tick();
        n_checks++; if (dut_head() !== b) $display("FAIL bp_head_b: got %h want %h", dut_head(), b); else n_pass++;
        n_checks++; if (ex_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", ex_ready); else n_pass++;
        tick();
        n_checks++; if (mem_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", mem_valid); else n_pass++;
    endtask

    task automatic test_lane_mask();
        mem_ready    = 1'b1;
        ex_valid     = 1'b1;
        ex_wen       = 4'b0101;
        ex_aluresult = {4{32'hFFFF_FFFF}};
        ex_storedata = {4{32'hFFFF_FFFF}};
        ex_woffset   = 16'hFFFF;
        tick();
        ex_valid = 1'b0;
        n_checks++; if (mem_aluresult !== 128'h00000000_FFFFFFFF_00000000_FFFFFFFF) $display("FAIL mask_alu: got %h", mem_aluresult); else n_pass++;
        n_checks++; if (mem_storedata !== 128'h00000000_FFFFFFFF_00000000_FFFFFFFF) $display("FAIL mask_sd: got %h", mem_storedata); else n_pass++;
        n_checks++; if (mem_woffset !== 16'h0F0F) $display("FAIL mask_woffset: got %h want 0f0f", mem_woffset); else n_pass++;
        n_checks++; if (mem_wen !== 4'b0101) $display("FAIL mask_wen: got %b want 0101", mem_wen); else n_pass++;
        tick();
        n_checks++; if (mem_wen !== 4'b0000 || mem_done !== 1'b0) $display("FAIL mask_idle_gating: got wen %b done %b want 0", mem_wen, mem_done); else n_pass++;
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        rand_beat(); tick();
        rand_beat(); tick();
        n_checks++; if (occupancy !== 2'd2) $display("FAIL flush_pre_occ: got %0d want 2", occupancy); else n_pass++;
        flush = 1'b1;
        rand_beat(); tick();
        flush    = 1'b0;
        ex_valid = 1'b0;
        n_checks++; if (mem_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", mem_valid); else n_pass++;
        n_checks++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (ex_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", ex_ready); else n_pass++;
        n_checks++; if (stall_cnt !== 4'(mcnt) || mcnt == 0) $display("FAIL flush_keeps_cnt: got %0d want %0d", stall_cnt, mcnt); else n_pass++;
        tick();
        n_checks++; if (mem_valid !== 1'b0) $display("FAIL flush_dropped: got %b want 0", mem_valid); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ex_valid  = ($urandom_range(0, 3) != 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rand_beat();
            tick();
            n_checks++; if (occupancy !== 2'(q.size())) $display("FAIL rnd_occ[%0d]: got %0d want %0d", i, occupancy, q.size()); else n_pass++;
            n_checks++; if (mem_valid !== (q.size() != 0)) $display("FAIL rnd_valid[%0d]: got %b want %b", i, mem_valid, q.size() != 0); else n_pass++;
            n_checks++; if (ex_ready !== (q.size() < 2)) $display("FAIL rnd_ready[%0d]: got %b want %b", i, ex_ready, q.size() < 2); else n_pass++;
            n_checks++; if (stall_cnt !== 4'(mcnt)) $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, stall_cnt, mcnt); else n_pass++;
            if (q.size() != 0) begin
                n_checks++; if (dut_head() !== q[0]) $display("FAIL rnd_head[%0d]: got %h want %h", i, dut_head(), q[0]); else n_pass++;
            end else begin
                n_checks++; if (mem_wen !== '0 || mem_done !== 1'b0) $display("FAIL rnd_idle[%0d]: got wen %b done %b want 0", i, mem_wen, mem_done); else n_pass++;
            end
        end
        flush     = 1'b0;
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_midstream();
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        rand_beat(); tick();
        rand_beat(); tick();
        ex_valid = 1'b0;
        n_checks++; if (occupancy !== 2'd2) $display("FAIL rst_pre_occ: got %0d want 2", occupancy); else n_pass++;
        #2;
        nRST = 1'b0;
        q.delete();
        mcnt = 0;
        #1;
        n_checks++; if (mem_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL rst_async: got valid %b occ %0d want 0", mem_valid, occupancy); else n_pass++;
        n_checks++; if (dut_head() !== '0 || stall_cnt !== 4'd0) $display("FAIL rst_async_zero: got %h cnt %0d want 0", dut_head(), stall_cnt); else n_pass++;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        n_checks++; if (ex_ready !== 1'b1 || occupancy !== 2'd0) $display("FAIL rst_release: got ready %b occ %0d want 1/0", ex_ready, occupancy); else n_pass++;
    endtask

    task automatic test_saturate();
        beat_t held;
        mem_ready = 1'b0;
        ex_valid  = 1'b1;
        rand_beat();
        held = in_beat();
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++; if (dut_head() !== held) $display("FAIL sat_stable[%0d]: got %h want %h", i, dut_head(), held); else n_pass++;
            n_checks++; if (stall_cnt !== 4'(mcnt)) $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_cnt, mcnt); else n_pass++;
        end
        n_checks++; if (stall_cnt !== 4'd15) $display("FAIL sat_final: got %0d want 15", stall_cnt); else n_pass++;
        mem_ready = 1'b1;
        tick();
    endtask

    initial begin
        nRST         = 1'b0;
        flush        = 1'b0;
        ex_valid     = 1'b0;
        mem_ready    = 1'b0;
        ex_wen       = '0;
        ex_aluresult = '0;
        ex_storedata = '0;
        ex_woffset   = '0;
        ex_ctrl      = '0;
        ex_index     = '0;
        ex_done      = 1'b0;
        mcnt         = 0;

        test_reset();
        test_stream();
        test_backpressure();
        test_lane_mask();
        test_flush();
        test_random();
        test_reset_midstream();
        test_saturate();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
